// File: rtl/cic_dec_pkg.sv
// cic_dec_pkg: shared widths, gain constants and the 18-bit saturation helper for the CIC decimator.
package cic_dec_pkg;
  localparam int STAGES = 3;
  localparam int ACC_W = 48;
  localparam int RATE_W = 10;
  localparam int DATA_W = 18;
  localparam int EXP_MAX = 30;
  localparam logic [DATA_W-1:0] MANT_ONE = 18'h20000;
  function automatic logic [DATA_W-1:0] sat18(input logic signed [ACC_W-1:0] v);
    return (v > 48'sd131071) ? 18'h1FFFF : (v < -48'sd131072) ? 18'h20000 : v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/cic_dec_core.sv
// cic_dec_core: cascaded integrators, decimation phase counter and single-stage comb chain.
module cic_dec_core
  import cic_dec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [RATE_W-1:0] decimation,
  output logic [ACC_W-1:0]  comb_out,
  output logic              comb_vld
);
  logic [ACC_W-1:0] integ_q [STAGES];
  logic [ACC_W-1:0] integ_d [STAGES];
  logic [ACC_W-1:0] dly_q [STAGES];
  logic [ACC_W-1:0] dly_d [STAGES];
  logic [ACC_W-1:0] comb_q, comb_d, acc, c;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, strobe;
  always_comb begin
    strobe = en && !clr && cnt_q >= decimation;
    cnt_d = clr ? '0 : !en ? cnt_q : strobe ? '0 : cnt_q + 1'b1;
    acc = {{(ACC_W-DATA_W){din[DATA_W-1]}}, din};
    for (int k = 0; k < STAGES; k++) begin
      integ_d[k] = clr ? '0 : en ? integ_q[k] + acc : integ_q[k];
      acc = integ_d[k];
    end
    // combs see the integrator value that includes the strobing sample
    c = acc;
    for (int k = 0; k < STAGES; k++) begin
      dly_d[k] = clr ? '0 : strobe ? c : dly_q[k];
      c = c - dly_q[k];
    end
    comb_d = strobe ? c : comb_q;
    vld_d = strobe;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      comb_q <= '0;
      vld_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        dly_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      comb_q <= comb_d;
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k] <= dly_d[k];
      end
    end
  assign comb_out = comb_q;
  assign comb_vld = vld_q;
endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: CIC decimator with exponent/mantissa gain, invert and bypass.
// Defining CIC_DEC_TEST_EN adds the test/testValue override ports.
module cic_decimator
  import cic_dec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clkEn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [RATE_W-1:0] decimation,
  input  logic [4:0]        exponent,
  input  logic [DATA_W-1:0] mantissa,
  input  logic              bypass,
  input  logic              invert,
`ifdef CIC_DEC_TEST_EN
  input  logic              test,
  input  logic [DATA_W-1:0] testValue,
`endif
  output logic [DATA_W-1:0] dataOut,
  output logic              dataOutEn
);
  logic bypass_q, clr, comb_vld;
  logic [ACC_W-1:0] comb_out;
  logic [DATA_W-1:0] p2_q, p2_d, p3_q, p3_d, out_q, out_d, src;
  logic p2_vld_q, p2_vld_d, p3_vld_q, p3_vld_d, out_en_q, out_en_d;
  logic [4:0] sh;
  logic signed [36:0] prod;
  cic_dec_core u_core (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .en(clkEn),
    .din(dataIn),
    .decimation(decimation),
    .comb_out(comb_out),
    .comb_vld(comb_vld)
  );
  always_comb begin
    clr = bypass_q && !bypass;
    sh = exponent > 5'(EXP_MAX) ? 5'(EXP_MAX) : exponent;
    p2_d = comb_vld ? DATA_W'((comb_out << sh) >> (ACC_W-DATA_W)) : p2_q;
    p2_vld_d = comb_vld && !clr;
    prod = 37'(signed'(p2_q)) * 37'(signed'({1'b0, mantissa}));
    p3_d = p2_vld_q ? sat18(ACC_W'((prod + 37'sd65536) >>> 17)) : p3_q;
    p3_vld_d = p2_vld_q && !clr;
    // a CIC sample still in flight when bypass drops must not leak out
    src = bypass ? dataIn : p3_q;
    out_en_d = bypass ? clkEn : p3_vld_q && !clr;
    out_d = out_en_d ? (invert ? sat18(-ACC_W'(signed'(src))) : src) : out_q;
`ifdef CIC_DEC_TEST_EN
    out_d = test ? testValue : out_d;
    out_en_d = test ? clkEn : out_en_d;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      bypass_q <= 1'b0;
      p2_q <= '0;
      p3_q <= '0;
      out_q <= '0;
      p2_vld_q <= 1'b0;
      p3_vld_q <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      bypass_q <= bypass;
      p2_q <= p2_d;
      p3_q <= p3_d;
      out_q <= out_d;
      p2_vld_q <= p2_vld_d;
      p3_vld_q <= p3_vld_d;
      out_en_q <= out_en_d;
    end
  assign dataOut = out_q;
  assign dataOutEn = out_en_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: random and directed stimulus checked every cycle against a behavioural CIC model.
module tb_cic_decimator;
  import cic_dec_pkg::*;
  localparam int NE = 4096;
  logic clk = 0, reset = 1, clkEn = 0, bypass = 0, invert = 0, dataOutEn;
  logic [17:0] dataIn = 0, mantissa = MANT_ONE, dataOut;
  logic [9:0] decimation = 0;
  logic [4:0] exponent = 0;
  int checks = 0, errors = 0, edge_n = 0;
  bit exp_en [NE];
  bit cic_en [NE];
  bit rst_mark [NE];
  logic [17:0] exp_d [NE];
  logic [17:0] cic_d [NE];
  logic [47:0] s [3];
  logic [47:0] h [3];
  int cnt = 0;
  bit bh = 0;
  logic [17:0] last = 0;

  cic_decimator dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .dataIn(dataIn), .decimation(decimation),
    .exponent(exponent), .mantissa(mantissa), .bypass(bypass), .invert(invert),
    .dataOut(dataOut), .dataOutEn(dataOutEn)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endfunction

  function automatic logic [17:0] sat(input longint v);
    return v > 131071 ? 18'h1FFFF : v < -131072 ? 18'h20000 : v[17:0];
  endfunction

  function automatic logic [17:0] gain(input logic [47:0] y);
    logic [95:0] t;
    longint g;
    t = {48'd0, y} << (exponent > 30 ? 30 : int'(exponent));
    g = longint'($signed(t[47:30]));
    return sat((g * longint'(mantissa) + 65536) >>> 17);
  endfunction

  // Behavioural model: running sums, decimated history, third difference by binomial weights.
  task automatic model_step(input int e);
    logic [47:0] x, y;
    bit clr;
    if (e + 3 >= NE) begin
      $display("FAIL bound: edge %0d exceeds model capacity %0d", e, NE);
      $fatal(1);
    end
    if (reset) begin
      for (int j = 0; j < 3; j++) begin s[j] = 0; h[j] = 0; cic_en[e+j] = 0; end
      cnt = 0; bh = 0; rst_mark[e] = 1; exp_en[e] = 0;
      return;
    end
    clr = bh && !bypass;
    bh = bypass;
    if (clr) begin
      for (int j = 0; j < 3; j++) begin s[j] = 0; h[j] = 0; cic_en[e+j] = 0; end
      cnt = 0;
    end else if (clkEn) begin
      x = {{30{dataIn[17]}}, dataIn};
      s[0] += x; s[1] += s[0]; s[2] += s[1];
      if (cnt >= int'(decimation)) begin
        cnt = 0;
        y = s[2] - 3 * h[0] + 3 * h[1] - h[2];
        h[2] = h[1]; h[1] = h[0]; h[0] = s[2];
        cic_en[e+3] = 1;
        cic_d[e+3] = gain(y);
      end else cnt++;
    end
    exp_en[e] = bypass ? clkEn : cic_en[e];
    exp_d[e] = bypass ? dataIn : cic_d[e];
    if (invert) exp_d[e] = sat(-longint'($signed(exp_d[e])));
  endtask

  task automatic tick();
    model_step(edge_n);
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic drain();
    clkEn = 0;
    repeat (5) tick();
  endtask

  task automatic wait_en(input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (!dataOutEn && n < max);
    if (!dataOutEn) n = -1;
  endtask

  always @(negedge clk)
    if (edge_n > 0) begin : cmp
      int k;
      k = edge_n - 1;
      if (rst_mark[k]) last = 0;
      else if (exp_en[k]) last = exp_d[k];
      chk("dataOutEn", longint'(dataOutEn), longint'(exp_en[k]));
      chk("dataOut", longint'($signed(dataOut)), longint'($signed(last)));
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, quiet;
    repeat (3) tick();
    chk("rst_out", longint'(dataOut), 0);
    chk("rst_en", longint'(dataOutEn), 0);
    reset = 0;
    decimation = 3; exponent = 24; mantissa = MANT_ONE; dataIn = 1000; clkEn = 1;
    wait_en(20, n);
    chk("dc_lat", n, 7);
    chk("dc_first", longint'($signed(dataOut)), 312);
    repeat (40) tick();
    chk("dc", longint'($signed(dataOut)), 1000);
    drain();
    mantissa = 18'h10000; dataIn = 1000; clkEn = 1;
    repeat (24) tick();
    chk("gain_half", longint'($signed(dataOut)), 500);
    drain();
    mantissa = MANT_ONE; dataIn = -18'sd1000; invert = 1; clkEn = 1;
    repeat (40) tick();
    chk("inv", longint'($signed(dataOut)), 1000);
    drain();
    decimation = 0; exponent = 30; mantissa = 18'h3FFFF; invert = 0; dataIn = 131071; clkEn = 1;
    repeat (12) tick();
    chk("sat_pos", longint'($signed(dataOut)), 131071);
    dataIn = 18'h20000; invert = 1;
    repeat (12) tick();
    chk("sat_neg", longint'($signed(dataOut)), 131071);
    for (int seg = 0; seg < 6; seg++) begin
      drain();
      exponent = 5'($urandom_range(14, 31));
      mantissa = 18'($urandom);
      invert = 1'($urandom_range(0, 1));
      decimation = 10'($urandom_range(0, 7));
      for (int i = 0; i < 150; i++) begin
        clkEn = 1'($urandom_range(0, 1));
        dataIn = 18'($urandom);
        bypass = (i >= 60 && i < 80);
        if (i % 50 == 49) decimation = 10'($urandom_range(0, 7));
        if (i % 37 == 0) invert = 1'($urandom_range(0, 1));
        tick();
      end
      bypass = 0;
    end
    drain();
    decimation = 3; exponent = 24; mantissa = MANT_ONE; invert = 0; bypass = 1;
    for (int i = 0; i < 9; i++) begin
      clkEn = 1; dataIn = 18'(i);
      tick();
      chk("byp_en", longint'(dataOutEn), 1);
      chk("byp_data", longint'(dataOut), i);
      clkEn = 0;
      tick();
      chk("byp_gap", longint'(dataOutEn), 0);
      tick();
    end
    bypass = 0; clkEn = 1; dataIn = 1000;
    wait_en(20, n);
    chk("byp_lat", n, 8);
    repeat (40) tick();
    chk("byp_dc", longint'($signed(dataOut)), 1000);
    drain();
    reset = 1;
    tick();
    reset = 0; decimation = 7; clkEn = 1;
    repeat (5) tick();
    decimation = 2;
    tick();
    clkEn = 0;
    wait_en(10, n);
    chk("rate_lat", n, 3);
    clkEn = 1;
    repeat (12) tick();
    drain();
    exponent = 30; mantissa = MANT_ONE; invert = 0; decimation = 0; clkEn = 1;
    for (int i = 0; i < 10; i++) begin dataIn = 18'(i * 7); tick(); end
    reset = 1;
    tick();
    chk("rstm_en", longint'(dataOutEn), 0);
    chk("rstm_out", longint'(dataOut), 0);
    reset = 0; clkEn = 0; quiet = 0;
    repeat (5) begin tick(); if (dataOutEn) quiet++; end
    chk("rstm_quiet", quiet, 0);
    clkEn = 1; dataIn = 500;
    tick();
    clkEn = 0;
    wait_en(10, n);
    chk("rstm_lat", n, 3);
    chk("rstm_fresh", longint'($signed(dataOut)), 500);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Receive-side counterpart of the transmit interpolation chain: an N-stage CIC decimator with programmable rate, exponent/mantissa gain normalisation, optional inversion and bypass.
- Accepts 18-bit samples at the high rate, qualified by clkEn.
- Emits 18-bit samples at 1/R of the input rate, qualified by a one-clock dataOutEn strobe for the downstream demod/filter stage.

Parameters:
- STAGES, 3, number of integrator and comb stages (differential delay M=1).
- ACC_W, 48, accumulator width; covers 18 + STAGES*log2(1024).
- RATE_W, 10, width of the decimation field; R = decimation+1, range 1..1024.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clkEn  in  1  input sample strobe; one clk per valid dataIn
- dataIn  in  18  signed input sample
- decimation  in  RATE_W  R-1
- exponent  in  5  gain shift 0..30; values above 30 clamp to 30
- mantissa  in  18  unsigned gain, 0x20000 = 1.0
- bypass  in  1  pass dataIn straight through
- invert  in  1  negate output
- dataOut  out  18  signed output sample
- dataOutEn  out  1  one-clk strobe, dataOut valid

Behaviour:
- Reset: dataOut=0, dataOutEn=0, all integrators, combs and pipeline registers 0, phase counter 0, bypass history 0.
- Integrators: on each clkEn, every stage accumulates in cascade, modulo 2^ACC_W (wrap is intended). Input is sign-extended to ACC_W.
- Phase counter: increments on clkEn. On a clkEn with count >= decimation, count returns to 0 and a decimate strobe is raised. decimation=0 gives R=1, strobe on every clkEn. Lowering decimation below the current count forces a strobe on the next clkEn.
- Comb chain: on the decimate strobe, each comb computes x - x_prev and stores x_prev, modulo 2^ACC_W. All combs are evaluated in the one registered stage (P1).
- Gain stage P2: combOut << exponent, then bits [ACC_W-1 -: 18].
- Gain stage P3: signed(P2) × unsigned mantissa gives a 37-bit product. Add 2^16, arithmetic shift right 17, saturate to [-131072, 131071].
- Output stage P4: apply optional negate. -(-131072) saturates to 131071. Register dataOut and assert dataOutEn.
- Latency: exactly 4 clk from the strobing clkEn to dataOutEn, fixed. The pipeline is strobe-propagated, so back-to-back strobes (R=1, clkEn every clk) are supported. dataOut holds its value between strobes.
- Bypass high: on each clkEn, dataOut <= dataIn (or its saturated negate); dataOutEn asserts 1 clk after clkEn. The CIC keeps running but its output is discarded.
- Bypass falling edge: detected as the registered bypass going 1->0. It issues a one-clk internal clear of integrators, combs, counter and P1-P3 valid bits. First non-bypass output appears after R fresh clkEn + 4 clk.
- Mid-operation reset: clears everything within the same edge; no strobe is emitted on that clk.
- Simultaneous clkEn and internal clear: clear wins; the sample is dropped.

Optional Feature:
- CIC_DEC_TEST_EN defined: adds ports test (in, 1) and testValue (in, 18). While test is high, dataOut <= testValue every clk and dataOutEn follows clkEn delayed by 1; test has priority over bypass.
- Undefined: the ports are absent and the behaviour is as above.

Decomposition:
- Package cic_dec_pkg holds: ACC_W, STAGES, RATE_W, DATA_W=18, EXP_MAX=30, the MANT_ONE=18'h20000 constant, and the sat18 saturation function.
- One sub-module, cic_dec_core, contains the integrators, phase counter and combs and outputs combOut plus a valid bit.
- The top level handles gain, invert, bypass and test.

Test Plan:
- DC: dataIn=1000 on every clk, decimation=3, exponent=24, mantissa=0x20000 -> dataOutEn every 4th clkEn; dataOut=1000 from the 3rd output onward (R^N=64, 64000·2^24/2^30).
- Gain: same setup with mantissa=0x10000 -> dataOut=500. Then dataIn=-1000, invert=1 -> dataOut=1000.
- Saturation: dataIn=131071, decimation=0, exponent=30, mantissa=0x3FFFF -> dataOut=131071. dataIn=-131072 with invert=1 -> dataOut=131071.
- Bypass: bypass=1, clkEn every 3rd clk, dataIn ramp 0,1,2… -> dataOut=dataIn 1 clk later, one strobe per clkEn. Drop bypass -> no strobe until R clkEn + 4 clk, then the DC value settles.
- Rate change: decimation 7->2 while count=5 -> strobe on the next clkEn, then every 3rd clkEn.
- Reset mid-stream: assert reset during the output pipeline -> dataOutEn stays 0 and the first output after release is the fresh transient, with no stale sample.
